// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, byte-addressable data memory
// with alignment checking, and MEM/WB register with forwarding taps.
module mem_stage #(
   parameter int ADDR_W = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] aluResult,
   input  logic [31:0] storeData,
   input  logic [4:0]  destReg,
   input  logic [5:0]  opcode,
   input  logic        regWrite,
   input  logic        memToReg,
   output logic [31:0] exmemResult,
   output logic [4:0]  exmemReg,
   output logic        exmemFwdValid,
   output logic [31:0] wbData,
   output logic [4:0]  wbReg,
   output logic        wbRegWrite,
   output logic        excecao,
   output logic [31:0] badAddr
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   logic [31:0] ex_addr_q, ex_addr_d;
   logic [31:0] ex_sd_q, ex_sd_d;
   logic [4:0]  ex_reg_q, ex_reg_d;
   logic [5:0]  ex_op_q, ex_op_d;
   logic        ex_rw_q, ex_rw_d;
   logic        ex_m2r_q, ex_m2r_d;

   logic [31:0] wb_data_q, wb_data_d;
   logic [4:0]  wb_reg_q, wb_reg_d;
   logic        wb_rw_q, wb_rw_d;
   logic        exc_q, exc_d;
   logic [31:0] bad_q, bad_d;

   logic [31:0] mem [2**ADDR_W];

   logic is_lb, is_lh, is_lw, is_lbu, is_lhu;
   logic is_sb, is_sh, is_sw;
   logic is_load, is_store, misaligned, mem_we;
   logic [ADDR_W-1:0] idx;
   logic [31:0] rd_word, load_data, wr_data;
   logic [15:0] rd_half;
   logic [7:0]  rd_byte;
   logic [3:0]  wr_be;

   always_comb begin
      is_lb  = ex_op_q == OP_LB;
      is_lh  = ex_op_q == OP_LH;
      is_lw  = ex_op_q == OP_LW;
      is_lbu = ex_op_q == OP_LBU;
      is_lhu = ex_op_q == OP_LHU;
      is_sb  = ex_op_q == OP_SB;
      is_sh  = ex_op_q == OP_SH;
      is_sw  = ex_op_q == OP_SW;
      is_load  = is_lb | is_lh | is_lw | is_lbu | is_lhu;
      is_store = is_sb | is_sh | is_sw;
      misaligned = ((is_lh | is_lhu | is_sh) & ex_addr_q[0]) |
                   ((is_lw | is_sw) & (ex_addr_q[1:0] != 2'd0));

      idx     = ex_addr_q[ADDR_W+1:2];
      rd_word = mem[idx];
      rd_half = ex_addr_q[1] ? rd_word[31:16] : rd_word[15:0];
      unique case (ex_addr_q[1:0])
         2'd0:    rd_byte = rd_word[7:0];
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase

      unique case (1'b1)
         is_lb:   load_data = {{24{rd_byte[7]}}, rd_byte};
         is_lbu:  load_data = {24'd0, rd_byte};
         is_lh:   load_data = {{16{rd_half[15]}}, rd_half};
         is_lhu:  load_data = {16'd0, rd_half};
         default: load_data = rd_word;
      endcase

      // Narrow stores replicate the datum so every lane sees it.
      unique case (1'b1)
         is_sb: begin
            wr_be   = 4'b0001 << ex_addr_q[1:0];
            wr_data = {4{ex_sd_q[7:0]}};
         end
         is_sh: begin
            wr_be   = ex_addr_q[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{ex_sd_q[15:0]}};
         end
         default: begin
            wr_be   = 4'b1111;
            wr_data = ex_sd_q;
         end
      endcase

      mem_we = is_store & ~misaligned & ~stall & reset;
   end

   always_comb begin
      ex_addr_d = ex_addr_q;
      ex_sd_d   = ex_sd_q;
      ex_reg_d  = ex_reg_q;
      ex_op_d   = ex_op_q;
      ex_rw_d   = ex_rw_q;
      ex_m2r_d  = ex_m2r_q;
      if (!stall) begin
         if (flush) begin
            ex_addr_d = '0;
            ex_sd_d   = '0;
            ex_reg_d  = '0;
            ex_op_d   = '0;
            ex_rw_d   = 1'b0;
            ex_m2r_d  = 1'b0;
         end else begin
            ex_addr_d = aluResult;
            ex_sd_d   = storeData;
            ex_reg_d  = destReg;
            ex_op_d   = opcode;
            ex_rw_d   = regWrite;
            ex_m2r_d  = memToReg;
         end
      end
   end

   always_comb begin
      wb_data_d = wb_data_q;
      wb_reg_d  = wb_reg_q;
      wb_rw_d   = wb_rw_q;
      exc_d     = 1'b0;
      bad_d     = bad_q;
      if (!stall) begin
         wb_data_d = ex_m2r_q ? load_data : ex_addr_q;
         wb_reg_d  = ex_reg_q;
         wb_rw_d   = ex_rw_q & ~misaligned & (ex_reg_q != 5'd0);
         exc_d     = misaligned;
         if (misaligned) bad_d = ex_addr_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         ex_addr_q <= '0;
         ex_sd_q   <= '0;
         ex_reg_q  <= '0;
         ex_op_q   <= '0;
         ex_rw_q   <= 1'b0;
         ex_m2r_q  <= 1'b0;
         wb_data_q <= '0;
         wb_reg_q  <= '0;
         wb_rw_q   <= 1'b0;
         exc_q     <= 1'b0;
         bad_q     <= '0;
      end else begin
         ex_addr_q <= ex_addr_d;
         ex_sd_q   <= ex_sd_d;
         ex_reg_q  <= ex_reg_d;
         ex_op_q   <= ex_op_d;
         ex_rw_q   <= ex_rw_d;
         ex_m2r_q  <= ex_m2r_d;
         wb_data_q <= wb_data_d;
         wb_reg_q  <= wb_reg_d;
         wb_rw_q   <= wb_rw_d;
         exc_q     <= exc_d;
         bad_q     <= bad_d;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign exmemResult   = ex_addr_q;
   assign exmemReg      = ex_reg_q;
   assign exmemFwdValid = ex_rw_q & ~is_load & (ex_reg_q != 5'd0);
   assign wbData        = wb_data_q;
   assign wbReg         = wb_reg_q;
   assign wbRegWrite    = wb_rw_q;
   assign excecao       = exc_q;
   assign badAddr       = bad_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a reference memory model and an
// in-flight scoreboard queue of expected write-back results.
module tb_mem_stage;

   logic        clock = 1'b0;
   logic        reset, stall, flush;
   logic [31:0] aluResult, storeData;
   logic [4:0]  destReg;
   logic [5:0]  opcode;
   logic        regWrite, memToReg;
   logic [31:0] exmemResult;
   logic [4:0]  exmemReg;
   logic        exmemFwdValid;
   logic [31:0] wbData;
   logic [4:0]  wbReg;
   logic        wbRegWrite, excecao;
   logic [31:0] badAddr;

   mem_stage #(.ADDR_W(8)) dut (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .aluResult(aluResult), .storeData(storeData),
      .destReg(destReg), .opcode(opcode),
      .regWrite(regWrite), .memToReg(memToReg),
      .exmemResult(exmemResult), .exmemReg(exmemReg),
      .exmemFwdValid(exmemFwdValid),
      .wbData(wbData), .wbReg(wbReg), .wbRegWrite(wbRegWrite),
      .excecao(excecao), .badAddr(badAddr)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [4:0]  rg;
      logic        rw;
      logic        m2r;
      logic [31:0] e_data;
      logic        e_rw;
      logic        e_fwd;
      logic        e_mis;
   } ent_t;

   ent_t        q[$];
   ent_t        last_wb;
   logic [31:0] mdl [256];
   logic [31:0] bad_m;
   int          checks = 0;
   int          failures = 0;

   function automatic ent_t mk(input logic [5:0] op,
                               input logic [31:0] addr,
                               input logic [31:0] sd,
                               input logic [4:0] rg,
                               input logic rw,
                               input logic m2r);
      ent_t e;
      e = '0;
      e.op = op; e.addr = addr; e.sd = sd;
      e.rg = rg; e.rw = rw; e.m2r = m2r;
      return e;
   endfunction

   function automatic logic is_ld(input logic [5:0] op);
      return op == 6'h20 || op == 6'h21 || op == 6'h23 ||
             op == 6'h24 || op == 6'h25;
   endfunction

   function automatic logic mis(input logic [5:0] op,
                                input logic [31:0] a);
      if (op == 6'h21 || op == 6'h25 || op == 6'h29) return a[0];
      if (op == 6'h23 || op == 6'h2B) return a[1:0] != 2'd0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ld(input logic [5:0] op,
                                      input logic [31:0] a);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      w = mdl[a[9:2]];
      case (a[1:0])
         2'd0: b = w[7:0];
         2'd1: b = w[15:8];
         2'd2: b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (op)
         6'h20: return {{24{b[7]}}, b};
         6'h24: return {24'd0, b};
         6'h21: return {{16{h[15]}}, h};
         6'h25: return {16'd0, h};
         default: return w;
      endcase
   endfunction

   function automatic ent_t fill(input ent_t e);
      ent_t r;
      r = e;
      r.e_mis  = mis(e.op, e.addr);
      r.e_rw   = e.rw & ~r.e_mis & (e.rg != 5'd0);
      r.e_fwd  = e.rw & ~is_ld(e.op) & (e.rg != 5'd0);
      r.e_data = e.m2r ? ld(e.op, e.addr) : e.addr;
      return r;
   endfunction

   task automatic commit(input ent_t e);
      int k;
      if (e.e_mis) return;
      k = int'(e.addr[1:0]);
      case (e.op)
         6'h28: mdl[e.addr[9:2]][8*k +: 8] = e.sd[7:0];
         6'h29: mdl[e.addr[9:2]][16*(k/2) +: 16] = e.sd[15:0];
         6'h2B: mdl[e.addr[9:2]] = e.sd;
         default: ;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input ent_t e, input bit st, input bit fl,
                      input bit rs);
      ent_t cur, nw;
      aluResult = e.addr; storeData = e.sd; destReg = e.rg;
      opcode = e.op; regWrite = e.rw; memToReg = e.m2r;
      stall = st; flush = fl; reset = ~rs;
      @(posedge clock);
      #1;
      if (rs) begin
         q.delete();
         q.push_back('0);
         last_wb = '0;
         bad_m = '0;
         chk("rst_exres", exmemResult, 32'd0);
         chk("rst_exreg", 32'(exmemReg), 32'd0);
         chk("rst_fwd", 32'(exmemFwdValid), 32'd0);
         chk("rst_wbdata", wbData, 32'd0);
         chk("rst_wbreg", 32'(wbReg), 32'd0);
         chk("rst_wbrw", 32'(wbRegWrite), 32'd0);
         chk("rst_exc", 32'(excecao), 32'd0);
         chk("rst_bad", badAddr, 32'd0);
      end else if (st) begin
         chk("stall_wbdata", wbData, last_wb.e_data);
         chk("stall_wbrw", 32'(wbRegWrite), 32'(last_wb.e_rw));
         chk("stall_exc", 32'(excecao), 32'd0);
         chk("stall_exres", exmemResult, q[0].addr);
      end else begin
         cur = q.pop_front();
         commit(cur);
         if (cur.e_mis) bad_m = cur.addr;
         last_wb = cur;
         chk("wbdata", wbData, cur.e_data);
         chk("wbreg", 32'(wbReg), 32'(cur.rg));
         chk("wbrw", 32'(wbRegWrite), 32'(cur.e_rw));
         chk("exc", 32'(excecao), 32'(cur.e_mis));
         chk("bad", badAddr, bad_m);
         nw = fill(fl ? ent_t'('0) : e);
         q.push_back(nw);
         chk("exres", exmemResult, nw.addr);
         chk("exreg", 32'(exmemReg), 32'(nw.rg));
         chk("fwd", 32'(exmemFwdValid), 32'(nw.e_fwd));
      end
   endtask

   ent_t nop;

   initial begin
      for (int i = 0; i < 256; i++) mdl[i] = '0;
      nop = mk(6'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      aluResult = '0; storeData = '0; destReg = '0;
      opcode = '0; regWrite = 1'b0; memToReg = 1'b0;

      cyc(nop, 0, 0, 1);
      cyc(nop, 0, 0, 1);
      cyc(mk(6'h2B, 32'h10, 32'hDEADBEEF, 0, 0, 0), 0, 0, 0);
      cyc(mk(6'h2B, 32'h20, 32'h11111111, 0, 0, 0), 0, 0, 0);
      cyc(mk(6'h2B, 32'h40, 32'h22222222, 0, 0, 0), 0, 0, 0);
      cyc(mk(6'h23, 32'h10, 32'h0, 5, 1, 1), 0, 0, 0);
      cyc(nop, 0, 0, 0);
      chk("lw_lit", wbData, 32'hDEADBEEF);
      chk("lw_reg", 32'(wbReg), 32'd5);
      chk("lw_rw", 32'(wbRegWrite), 32'd1);

      cyc(mk(6'h20, 32'h13, 0, 6, 1, 1), 0, 0, 0);
      cyc(mk(6'h24, 32'h13, 0, 7, 1, 1), 0, 0, 0);
      chk("lb_lit", wbData, 32'hFFFFFFDE);
      cyc(mk(6'h21, 32'h12, 0, 8, 1, 1), 0, 0, 0);
      chk("lbu_lit", wbData, 32'h000000DE);
      cyc(mk(6'h25, 32'h10, 0, 9, 1, 1), 0, 0, 0);
      chk("lh_lit", wbData, 32'hFFFFDEAD);
      cyc(nop, 0, 0, 0);
      chk("lhu_lit", wbData, 32'h0000BEEF);

      cyc(mk(6'h28, 32'h11, 32'h12, 0, 0, 0), 0, 0, 0);
      cyc(mk(6'h23, 32'h410, 0, 4, 1, 1), 0, 0, 0);
      cyc(nop, 0, 0, 0);
      chk("sb_lit", wbData, 32'hDEAD12EF);

      cyc(mk(6'h23, 32'h22, 0, 10, 1, 0), 0, 0, 0);
      cyc(nop, 0, 0, 0);
      chk("mis_exc", 32'(excecao), 32'd1);
      chk("mis_bad", badAddr, 32'h22);
      chk("mis_rw", 32'(wbRegWrite), 32'd0);
      cyc(nop, 0, 0, 0);
      chk("mis_pulse", 32'(excecao), 32'd0);

      cyc(mk(6'h2B, 32'h41, 32'h99999999, 0, 0, 0), 0, 0, 0);
      cyc(mk(6'h23, 32'h40, 0, 11, 1, 1), 0, 0, 0);
      chk("sw_mis_exc", 32'(excecao), 32'd1);
      cyc(nop, 0, 0, 0);
      chk("sw_mis_old", wbData, 32'h22222222);

      cyc(mk(6'h2B, 32'h30, 32'h5, 0, 0, 0), 0, 0, 0);
      cyc(mk(6'h2B, 32'h30, 32'h77, 0, 0, 0), 1, 0, 0);
      cyc(mk(6'h2B, 32'h30, 32'h77, 0, 0, 0), 1, 1, 0);
      cyc(mk(6'h2B, 32'h30, 32'h77, 0, 0, 0), 1, 0, 0);
      cyc(mk(6'h23, 32'h30, 0, 12, 1, 1), 0, 0, 0);
      cyc(nop, 0, 0, 0);
      chk("stall_lit", wbData, 32'h5);

      cyc(mk(6'h00, 32'h1234, 0, 7, 1, 0), 0, 1, 0);
      chk("flush_fwd", 32'(exmemFwdValid), 32'd0);
      cyc(mk(6'h00, 32'h5678, 0, 7, 1, 0), 0, 0, 0);
      chk("flush_wbrw", 32'(wbRegWrite), 32'd0);
      chk("alu_fwd", 32'(exmemFwdValid), 32'd1);
      cyc(mk(6'h00, 32'h9ABC, 0, 0, 1, 0), 0, 0, 0);
      chk("r0_fwd", 32'(exmemFwdValid), 32'd0);
      cyc(nop, 0, 0, 0);
      chk("r0_wbrw", 32'(wbRegWrite), 32'd0);

      cyc(mk(6'h2B, 32'h10, 32'hCAFEF00D, 0, 0, 0), 0, 0, 0);
      cyc(nop, 0, 0, 1);
      cyc(mk(6'h23, 32'h10, 0, 3, 1, 1), 0, 0, 0);
      cyc(nop, 0, 0, 0);
      chk("rst_drop", wbData, 32'hDEAD12EF);
      cyc(nop, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
